// File: rtl/ysyx_22040759_lsu_axi_bridge_pkg.sv
// ysyx_22040759_lsu_axi_bridge_pkg: AXI constants, access-size codes and FSM states for the LSU AXI bridge
package ysyx_22040759_lsu_axi_bridge_pkg;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] SIZE_B      = 2'b00;
    localparam logic [1:0] SIZE_H      = 2'b01;
    localparam logic [1:0] SIZE_W      = 2'b10;
    localparam logic [1:0] SIZE_D      = 2'b11;
    typedef enum logic [2:0] {S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_REQ, S_WR_RESP, S_DONE} state_e;
    // Low address bits that must be zero for a naturally aligned access
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        return size == SIZE_D ? 3'b111 : size == SIZE_W ? 3'b011 : size == SIZE_H ? 3'b001 : 3'b000;
    endfunction
endpackage

// File: rtl/ysyx_22040759_lsu_lane_align.sv
// ysyx_22040759_lsu_lane_align: byte-lane strobe, write-data shift and read-data shift/mask for 64-bit AXI
module ysyx_22040759_lsu_lane_align
    import ysyx_22040759_lsu_axi_bridge_pkg::*;
(
    input  logic [2:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] rdata_i,
    output logic [63:0] wdata_o,
    output logic [7:0]  wstrb_o,
    output logic [63:0] rdata_o
);
    logic [5:0]  sh;
    logic [7:0]  bmask;
    logic [63:0] dmask;
    always_comb begin
        sh      = {off_i, 3'b000};
        bmask   = size_i == SIZE_D ? 8'hff : size_i == SIZE_W ? 8'h0f : size_i == SIZE_B ? 8'h01 : 8'h03;
        dmask   = size_i == SIZE_D ? '1 : size_i == SIZE_W ? 64'hffff_ffff :
                  size_i == SIZE_B ? 64'hff : 64'hffff;
        wdata_o = wdata_i << sh;
        wstrb_o = bmask << off_i;
        rdata_o = (rdata_i >> sh) & dmask;
    end
endmodule

// File: rtl/ysyx_22040759_lsu_axi_bridge.sv
// ysyx_22040759_lsu_axi_bridge: turns one MEM-stage load/store into a single-beat AXI4 transaction
module ysyx_22040759_lsu_axi_bridge
    import ysyx_22040759_lsu_axi_bridge_pkg::*;
#(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 64,
    parameter int AXI_ID_W   = 4,
    parameter int AXI_ID     = 1
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_valid_i,
    output logic                    mem_ready_o,
    input  logic                    mem_req_i,
    input  logic [63:0]             mem_addr_i,
    input  logic [1:0]              mem_size_i,
    input  logic [63:0]             mem_data_write_i,
    output logic [63:0]             mem_data_read_o,
    output logic [1:0]              mem_resp_o,
    output logic                    axi_aw_valid_o,
    input  logic                    axi_aw_ready_i,
    output logic [AXI_ADDR_W-1:0]   axi_aw_addr_o,
    output logic [AXI_ID_W-1:0]     axi_aw_id_o,
    output logic [7:0]              axi_aw_len_o,
    output logic [2:0]              axi_aw_size_o,
    output logic [1:0]              axi_aw_burst_o,
    output logic                    axi_w_valid_o,
    input  logic                    axi_w_ready_i,
    output logic [AXI_DATA_W-1:0]   axi_w_data_o,
    output logic [AXI_DATA_W/8-1:0] axi_w_strb_o,
    output logic                    axi_w_last_o,
    input  logic                    axi_b_valid_i,
    output logic                    axi_b_ready_o,
    input  logic [1:0]              axi_b_resp_i,
    input  logic [AXI_ID_W-1:0]     axi_b_id_i,
    output logic                    axi_ar_valid_o,
    input  logic                    axi_ar_ready_i,
    output logic [AXI_ADDR_W-1:0]   axi_ar_addr_o,
    output logic [AXI_ID_W-1:0]     axi_ar_id_o,
    output logic [7:0]              axi_ar_len_o,
    output logic [2:0]              axi_ar_size_o,
    output logic [1:0]              axi_ar_burst_o,
    input  logic                    axi_r_valid_i,
    output logic                    axi_r_ready_o,
    input  logic [AXI_DATA_W-1:0]   axi_r_data_i,
    input  logic [1:0]              axi_r_resp_i,
    input  logic                    axi_r_last_i,
    input  logic [AXI_ID_W-1:0]     axi_r_id_i
);
    state_e                  state_q;
    logic [AXI_ADDR_W-1:0]   addr_q;
    logic [1:0]              size_q;
    logic [63:0]             data_q, rdata_q, rdata_al;
    logic [1:0]              resp_q;
    logic                    ar_valid_q, aw_valid_q, w_valid_q, r_ready_q, b_ready_q, mem_ready_q;
    logic                    aw_fin, w_fin;
    logic                    unused_ok;

    ysyx_22040759_lsu_lane_align u_align (
        .off_i   (addr_q[2:0]),
        .size_i  (size_q),
        .wdata_i (data_q),
        .rdata_i (axi_r_data_i),
        .wdata_o (axi_w_data_o),
        .wstrb_o (axi_w_strb_o),
        .rdata_o (rdata_al)
    );

    assign aw_fin          = !aw_valid_q || axi_aw_ready_i;
    assign w_fin           = !w_valid_q || axi_w_ready_i;
    assign mem_ready_o     = mem_ready_q;
    assign mem_data_read_o = rdata_q;
    assign mem_resp_o      = resp_q;
    assign axi_ar_valid_o  = ar_valid_q;
    assign axi_ar_addr_o   = addr_q;
    assign axi_ar_id_o     = AXI_ID_W'(AXI_ID);
    assign axi_ar_len_o    = 8'd0;
    assign axi_ar_size_o   = {1'b0, size_q};
    assign axi_ar_burst_o  = BURST_INCR;
    assign axi_aw_valid_o  = aw_valid_q;
    assign axi_aw_addr_o   = addr_q;
    assign axi_aw_id_o     = AXI_ID_W'(AXI_ID);
    assign axi_aw_len_o    = 8'd0;
    assign axi_aw_size_o   = {1'b0, size_q};
    assign axi_aw_burst_o  = BURST_INCR;
    assign axi_w_valid_o   = w_valid_q;
    assign axi_w_last_o    = 1'b1;
    assign axi_r_ready_o   = r_ready_q;
    assign axi_b_ready_o   = b_ready_q;
    assign unused_ok       = ^{axi_r_last_i, axi_r_id_i, axi_b_id_i, mem_addr_i[63:AXI_ADDR_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ar_valid_q  <= 1'b0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            r_ready_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            mem_ready_q <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= RESP_OKAY;
        end else begin
            case (state_q)
                S_IDLE: if (mem_valid_i) begin
                    addr_q <= mem_addr_i[AXI_ADDR_W-1:0];
                    size_q <= mem_size_i;
                    data_q <= mem_data_write_i;
                    if ((mem_addr_i[2:0] & align_mask(mem_size_i)) != 3'b000) begin
                        resp_q      <= RESP_SLVERR;
                        mem_ready_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (mem_req_i) begin
                        aw_valid_q <= 1'b1;
                        w_valid_q  <= 1'b1;
                        state_q    <= S_WR_REQ;
                    end else begin
                        ar_valid_q <= 1'b1;
                        state_q    <= S_RD_ADDR;
                    end
                end
                S_RD_ADDR: if (axi_ar_ready_i) begin
                    ar_valid_q <= 1'b0;
                    r_ready_q  <= 1'b1;
                    state_q    <= S_RD_DATA;
                end
                S_RD_DATA: if (axi_r_valid_i) begin
                    rdata_q     <= rdata_al;
                    resp_q      <= axi_r_resp_i;
                    r_ready_q   <= 1'b0;
                    mem_ready_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                // AW and W complete independently; B is only accepted once both have gone
                S_WR_REQ: begin
                    if (axi_aw_ready_i) aw_valid_q <= 1'b0;
                    if (axi_w_ready_i) w_valid_q <= 1'b0;
                    if (aw_fin && w_fin) begin
                        b_ready_q <= 1'b1;
                        state_q   <= S_WR_RESP;
                    end
                end
                S_WR_RESP: if (axi_b_valid_i) begin
                    resp_q      <= axi_b_resp_i;
                    b_ready_q   <= 1'b0;
                    mem_ready_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                default: begin
                    mem_ready_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22040759_lsu_axi_bridge.sv
// tb_ysyx_22040759_lsu_axi_bridge: table-driven requests against a reactive AXI slave with a completion scoreboard
module tb_ysyx_22040759_lsu_axi_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0, mem_req = 1'b0;
    logic [63:0] mem_addr = '0, mem_wdata = '0;
    logic [1:0]  mem_size = '0;
    logic        mem_ready_o;
    logic [63:0] mem_data_read_o;
    logic [1:0]  mem_resp_o;
    logic        aw_valid_o, aw_ready = 1'b0, w_valid_o, w_ready = 1'b0, w_last_o;
    logic        b_valid = 1'b0, b_ready_o, ar_valid_o, ar_ready = 1'b0, r_valid = 1'b0, r_ready_o;
    logic [31:0] aw_addr_o, ar_addr_o;
    logic [3:0]  aw_id_o, ar_id_o;
    logic [7:0]  aw_len_o, ar_len_o, w_strb_o;
    logic [2:0]  aw_size_o, ar_size_o;
    logic [1:0]  aw_burst_o, ar_burst_o, b_resp = '0, r_resp = '0;
    logic [63:0] w_data_o, r_data = '0;

    always #5 clk = ~clk;

    ysyx_22040759_lsu_axi_bridge dut (
        .clk(clk), .rst(rst),
        .mem_valid_i(mem_valid), .mem_ready_o(mem_ready_o), .mem_req_i(mem_req), .mem_addr_i(mem_addr),
        .mem_size_i(mem_size), .mem_data_write_i(mem_wdata), .mem_data_read_o(mem_data_read_o), .mem_resp_o(mem_resp_o),
        .axi_aw_valid_o(aw_valid_o), .axi_aw_ready_i(aw_ready), .axi_aw_addr_o(aw_addr_o), .axi_aw_id_o(aw_id_o),
        .axi_aw_len_o(aw_len_o), .axi_aw_size_o(aw_size_o), .axi_aw_burst_o(aw_burst_o),
        .axi_w_valid_o(w_valid_o), .axi_w_ready_i(w_ready), .axi_w_data_o(w_data_o), .axi_w_strb_o(w_strb_o),
        .axi_w_last_o(w_last_o),
        .axi_b_valid_i(b_valid), .axi_b_ready_o(b_ready_o), .axi_b_resp_i(b_resp), .axi_b_id_i(4'd1),
        .axi_ar_valid_o(ar_valid_o), .axi_ar_ready_i(ar_ready), .axi_ar_addr_o(ar_addr_o), .axi_ar_id_o(ar_id_o),
        .axi_ar_len_o(ar_len_o), .axi_ar_size_o(ar_size_o), .axi_ar_burst_o(ar_burst_o),
        .axi_r_valid_i(r_valid), .axi_r_ready_o(r_ready_o), .axi_r_data_i(r_data), .axi_r_resp_i(r_resp),
        .axi_r_last_i(1'b1), .axi_r_id_i(4'd1)
    );

    typedef struct {
        logic        req;
        logic [63:0] addr;
        logic [1:0]  size;
        logic [63:0] wdata;
        logic [63:0] sdata;
        logic [1:0]  sresp;
        int          aw;
        int          ww;
        int          rb;
        logic        chk_data;
        logic [63:0] exp_data;
        logic [1:0]  exp_resp;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_strb;
        logic        axi;
        int          lat;
        int          t0;
    } vec_t;

    vec_t        sb[$];
    vec_t        tbl[12];
    int          checks = 0, errors = 0, cur = -1, cyc = 0, done_n = 0;
    int          cfg_a = 0, cfg_w = 0, cfg_rb = 0, a_cnt = 0, w_cnt = 0, ar_cnt = 0, rb_cnt = 0;
    logic [63:0] cfg_data = '0;
    logic [1:0]  cfg_resp = '0;
    logic        r_pend = 0, b_pend = 0, aw_seen = 0, w_seen = 0, axi_seen = 0, cap_wr = 0, prev_ready = 0;
    logic [31:0] cap_addr = '0;
    logic [2:0]  cap_size = '0;
    logic [63:0] cap_wdata = '0;
    logic [7:0]  cap_strb = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d): got %h expected %h", n, cur, act, exp);
        end
    endtask

    // One negedge: AXI slave reacts to the DUT, then the completion monitor runs
    task automatic tick();
        vec_t e;
        @(negedge clk);
        if (rst) begin
            ar_ready = 0; aw_ready = 0; w_ready = 0; r_valid = 0; b_valid = 0;
            r_pend = 0; b_pend = 0; aw_seen = 0; w_seen = 0; axi_seen = 0;
            a_cnt = 0; w_cnt = 0; ar_cnt = 0; rb_cnt = 0;
        end else begin
            if (ar_valid_o || aw_valid_o || w_valid_o) axi_seen = 1;
            if (r_valid) r_valid = 0;
            if (b_valid) begin b_valid = 0; aw_seen = 0; w_seen = 0; end
            if (ar_ready) begin
                ar_ready = 0; r_pend = 1; rb_cnt = 0;
            end else if (ar_valid_o) begin
                cap_addr = ar_addr_o; cap_size = ar_size_o; cap_wr = 0;
                if (ar_cnt >= cfg_a) begin
                    ar_ready = 1; ar_cnt = 0;
                    chk("ar_len", 64'(ar_len_o), 64'd0);
                    chk("ar_burst", 64'(ar_burst_o), 64'd1);
                    chk("ar_id", 64'(ar_id_o), 64'd1);
                end else ar_cnt++;
            end
            if (aw_ready) begin
                aw_ready = 0; aw_seen = 1;
            end else if (aw_valid_o) begin
                cap_addr = aw_addr_o; cap_size = aw_size_o; cap_wr = 1;
                if (a_cnt >= cfg_a) begin
                    aw_ready = 1; a_cnt = 0;
                    chk("aw_len", 64'(aw_len_o), 64'd0);
                    chk("aw_burst", 64'(aw_burst_o), 64'd1);
                    chk("aw_id", 64'(aw_id_o), 64'd1);
                end else a_cnt++;
            end
            if (w_ready) begin
                w_ready = 0; w_seen = 1;
            end else if (w_valid_o) begin
                cap_wdata = w_data_o; cap_strb = w_strb_o;
                if (w_cnt >= cfg_w) begin
                    w_ready = 1; w_cnt = 0;
                    chk("w_last", 64'(w_last_o), 64'd1);
                end else w_cnt++;
            end
            if (b_ready_o) chk("b_ready_after_aw_w", 64'(aw_seen && w_seen), 64'd1);
            if (aw_seen && w_seen && !b_pend && !b_valid) begin b_pend = 1; rb_cnt = 0; end
            if (r_pend) begin
                if (rb_cnt >= cfg_rb) begin r_valid = 1; r_data = cfg_data; r_resp = cfg_resp; r_pend = 0; end
                else rb_cnt++;
            end
            if (b_pend) begin
                if (rb_cnt >= cfg_rb) begin b_valid = 1; b_resp = cfg_resp; b_pend = 0; end
                else rb_cnt++;
            end
        end
        if (prev_ready) chk("ready_one_cycle", 64'(mem_ready_o), 64'd0);
        if (mem_ready_o && !prev_ready) begin
            if (sb.size() == 0) chk("spurious_ready", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                chk("resp", 64'(mem_resp_o), 64'(e.exp_resp));
                if (e.chk_data) chk("rdata", mem_data_read_o, e.exp_data);
                chk("latency", 64'(cyc - e.t0), 64'(e.lat));
                chk("axi_traffic", 64'(axi_seen), 64'(e.axi));
                if (e.axi) begin
                    chk("ax_dir", 64'(cap_wr), 64'(e.req));
                    chk("ax_addr", 64'(cap_addr), 64'(e.addr[31:0]));
                    chk("ax_size", 64'(cap_size), 64'({1'b0, e.size}));
                    if (e.req) begin
                        chk("w_data", cap_wdata, e.exp_wdata);
                        chk("w_strb", 64'(cap_strb), 64'(e.exp_strb));
                    end
                end
                axi_seen = 0;
                done_n++;
            end
        end
        prev_ready = mem_ready_o;
    endtask

    task automatic send(input vec_t v);
        int d0, n;
        cfg_a = v.aw; cfg_w = v.ww; cfg_rb = v.rb; cfg_data = v.sdata; cfg_resp = v.sresp;
        mem_valid = 1; mem_req = v.req; mem_addr = v.addr; mem_size = v.size; mem_wdata = v.wdata;
        v.t0 = cyc;
        sb.push_back(v);
        d0 = done_n;
        n = 0;
        while (done_n == d0 && n < 100) begin tick(); n++; end
        if (done_n == d0) begin
            chk("completion_timeout", 64'd1, 64'd0);
            sb.delete();
        end
        mem_valid = 0;
    endtask

    initial begin
        int n;
        vec_t fin;
        // req addr size wdata | slave data/resp, waits ar|aw, w, r|b | chk_data exp_data exp_resp exp_wdata exp_strb axi lat t0
        tbl[0]  = '{0, 64'h80000008, 2'd3, 64'h0, 64'h1122334455667788, 2'b00, 0, 0, 3, 1, 64'h1122334455667788, 2'b00, 64'h0, 8'h00, 1, 6, 0};
        tbl[1]  = '{0, 64'h80000005, 2'd0, 64'h0, 64'hAABBCCDDEEFF0011, 2'b00, 1, 0, 0, 1, 64'hCC, 2'b00, 64'h0, 8'h00, 1, 4, 0};
        tbl[2]  = '{1, 64'h80000002, 2'd1, 64'hBEEF, 64'h0, 2'b00, 0, 2, 0, 1, 64'hCC, 2'b00, 64'h00000000BEEF0000, 8'h0C, 1, 5, 0};
        tbl[3]  = '{1, 64'h80000001, 2'd2, 64'h12345678, 64'h0, 2'b00, 0, 0, 0, 1, 64'hCC, 2'b10, 64'h0, 8'h00, 0, 1, 0};
        tbl[4]  = '{0, 64'h80000004, 2'd2, 64'h0, 64'h8765432100000000, 2'b10, 0, 0, 0, 1, 64'h87654321, 2'b10, 64'h0, 8'h00, 1, 3, 0};
        tbl[5]  = '{0, 64'h80000006, 2'd1, 64'h0, 64'hA1B2C3D4E5F60718, 2'b00, 0, 0, 1, 1, 64'hA1B2, 2'b00, 64'h0, 8'h00, 1, 4, 0};
        tbl[6]  = '{1, 64'h80000010, 2'd3, 64'h0123456789ABCDEF, 64'h0, 2'b00, 3, 0, 1, 1, 64'hA1B2, 2'b00, 64'h0123456789ABCDEF, 8'hFF, 1, 7, 0};
        tbl[7]  = '{1, 64'h80000007, 2'd0, 64'hFFFFFFFFFFFFFF5A, 64'h0, 2'b11, 1, 1, 0, 1, 64'hA1B2, 2'b11, 64'h5A00000000000000, 8'h80, 1, 4, 0};
        tbl[8]  = '{0, 64'h80000004, 2'd3, 64'h0, 64'h0, 2'b00, 0, 0, 0, 0, 64'h0, 2'b10, 64'h0, 8'h00, 0, 1, 0};
        tbl[9]  = '{0, 64'h80000003, 2'd1, 64'h0, 64'h0, 2'b00, 0, 0, 0, 0, 64'h0, 2'b10, 64'h0, 8'h00, 0, 1, 0};
        tbl[10] = '{0, 64'h80000000, 2'd2, 64'h0, 64'hFFFFFFFF12345678, 2'b00, 0, 0, 0, 1, 64'h12345678, 2'b00, 64'h0, 8'h00, 1, 3, 0};
        tbl[11] = '{1, 64'h8000000C, 2'd2, 64'hCAFEF00D, 64'h0, 2'b00, 1, 1, 2, 1, 64'h12345678, 2'b00, 64'hCAFEF00D00000000, 8'hF0, 1, 6, 0};
        repeat (3) tick();
        chk("rst_mem_ready", 64'(mem_ready_o), 64'd0);
        chk("rst_valids", 64'({ar_valid_o, aw_valid_o, w_valid_o}), 64'd0);
        chk("rst_readys", 64'({r_ready_o, b_ready_o}), 64'd0);
        chk("rst_rdata", mem_data_read_o, 64'd0);
        chk("rst_resp", 64'(mem_resp_o), 64'd0);
        rst = 0;
        tick();
        for (int i = 0; i < 12; i++) begin
            cur = i;
            send(tbl[i]);
            tick();
        end
        // Reset while the DUT waits in RD_DATA abandons the load silently
        cur = 100;
        cfg_a = 0; cfg_rb = 40; cfg_data = 64'h5555; cfg_resp = 2'b00;
        mem_valid = 1; mem_req = 0; mem_addr = 64'h80000020; mem_size = 2'd3;
        n = 0;
        do begin tick(); n++; end while (!r_ready_o && n < 20);
        chk("reach_rd_data", 64'(r_ready_o), 64'd1);
        mem_valid = 0;
        rst = 1;
        tick();
        chk("mid_rst_r_ready", 64'(r_ready_o), 64'd0);
        chk("mid_rst_ar_valid", 64'(ar_valid_o), 64'd0);
        chk("mid_rst_rdata", mem_data_read_o, 64'd0);
        rst = 0;
        repeat (6) begin
            tick();
            chk("no_ready_after_rst", 64'(mem_ready_o), 64'd0);
        end
        cur = 101;
        fin = '{0, 64'h80000018, 2'd3, 64'h0, 64'hDEADBEEF01234567, 2'b00, 0, 0, 0, 1, 64'hDEADBEEF01234567, 2'b00, 64'h0, 8'h00, 1, 3, 0};
        send(fin);
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_22040759_lsu_axi_bridge.md
Name: ysyx_22040759_lsu_axi_bridge

Overview:
Responder end of the MEM-stage load/store request interface (mem_valid/mem_ready/mem_req/mem_size/mem_resp). Accepts one request at a time and turns it into a single-beat AXI4 master transaction (AR/R for loads, AW/W/B for stores). Returns lane-aligned read data and the AXI response code. Sits between the MEM stage and the top-level AXI arbiter.

Parameters:
AXI_ADDR_W, 32, AXI address width; mem_addr[AXI_ADDR_W-1:0] is used.
AXI_DATA_W, 64, AXI data width; only 64 is supported.
AXI_ID_W, 4, AXI ID width.
AXI_ID, 1, constant ID driven on ARID/AWID.

Ports:
clk  in  1  clock
rst  in  1  reset
mem_valid  in  1  request pending; requester holds it and all request fields stable until mem_ready
mem_ready  out  1  one-cycle pulse: request complete, mem_data_read/mem_resp valid
mem_req  in  1  1 = store, 0 = load
mem_addr  in  64  byte address
mem_size  in  2  00 B, 01 H, 10 W, 11 D
mem_data_write  in  64  store data, right-aligned (LSBs)
mem_data_read  out  64  load data, shifted down to bit 0, zero-filled above size
mem_resp  out  2  AXI RRESP/BRESP, or 2'b10 for a misaligned request
axi_aw_valid/ready/addr/id/len/size/burst  out/in/out...  AXI4 AW (len 0, burst INCR, size = mem_size)
axi_w_valid/ready/data/strb/last  out/in/out  AXI4 W (last = 1)
axi_b_valid/ready/resp/id  in/out/in/in  AXI4 B
axi_ar_valid/ready/addr/id/len/size/burst  AXI4 AR (same encoding as AW)
axi_r_valid/ready/data/resp/last/id  in/out/in/in/in/in  AXI4 R

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. FSM goes to IDLE. All *_valid, *_ready, mem_ready are 0. mem_data_read and mem_resp are 0. A reset mid-transaction abandons it with no completion pulse.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE: if mem_valid, latch addr/size/req/data into request registers in cycle t.
  - Misaligned (addr not multiple of 2^size) -> DONE, resp = 2'b10, no AXI traffic.
  - Else load -> RD_ADDR; store -> WR_REQ.
- RD_ADDR: ar_valid = 1 from t+1; hold until ar_ready; then -> RD_DATA.
- RD_DATA: r_ready = 1. On r_valid, register data >> (addr[2:0]*8), masked to size. Register r_resp, then -> DONE.
- WR_REQ: aw_valid and w_valid both rise at t+1. Each drops independently after its own handshake. When both are done (same or different cycles) -> WR_RESP.
  - w_data = data << (addr[2:0]*8).
  - w_strb = ((1<<(1<<size))-1) << addr[2:0].
- WR_RESP: b_ready = 1. On b_valid, register b_resp, then -> DONE.
- DONE: mem_ready = 1 for exactly one cycle, then -> IDLE. A new request is accepted no earlier than the cycle after DONE.
- Best-case load latency: request at t, AR handshake at t+1, R at t+2, mem_ready at t+3.
- One outstanding transaction only. R/B ID is not checked. Read data is not sign-extended; the requester extends per func3.
- AXI rule: valids never depend combinationally on the matching ready. Addresses and data stay stable while valid is high and ready is low.
- Stores ignore mem_data_read, which keeps its previous value.

Decomposition:
- Shared define file entries: AXI constants (BURST_INCR, RESP_OKAY/SLVERR), size encodings, FSM state localparams.
- One natural sub-module, ysyx_22040759_lsu_lane_align: combinational strobe generation, write-data shift, and read-data shift/mask.

Test Plan:
- Aligned LD: addr 0x80000008, size 11; slave returns 0x1122334455667788 after 3 wait cycles -> ar_addr 0x80000008, ar_size 3, mem_data_read 0x1122334455667788, mem_resp 00, one mem_ready pulse.
- LB: addr 0x80000005, size 00; R data 0xAABBCCDDEEFF0011 -> mem_data_read 0x00000000000000CC.
- SH: addr 0x80000002, data 0xBEEF, aw_ready 2 cycles before w_ready -> w_data 0x00000000BEEF0000, w_strb 0x0C, b_ready only after both handshakes, mem_ready after B.
- Misaligned SW at 0x80000001 -> no AXI valids, mem_ready at t+1 with mem_resp 10.
- Slave returns RRESP 10 on an LW -> mem_resp 10 forwarded.
- rst asserted while in RD_DATA -> next cycle IDLE, r_ready 0, no mem_ready pulse; a later request completes normally.
